// File: rtl/bdiv56x28.sv
// bdiv56x28: sequential radix-2 restoring divider, 2W/W -> W quotient and W remainder.
// One quotient bit per cycle, valid/ready handshake on both sides.
module bdiv56x28 #(
  parameter int W = 28
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] N,
  input  logic [W-1:0]   D,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   Q,
  output logic [W-1:0]   Rem,
  output logic           ovf
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W:0]    r_q, r_d;
  logic [W-1:0]  s_q, s_d;
  logic [W-1:0]  dv_q, dv_d;
  logic [W-1:0]  qa_q, qa_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          ovf_q, ovf_d;

  logic [W-1:0]  n_hi;
  logic [W-1:0]  n_lo;
  logic          accept;
  logic          n_ovf;
  logic [W:0]    t;
  logic [W:0]    diff;
  logic          qbit;
  logic [W:0]    r_next;
  logic [W-1:0]  qa_next;
  logic          last;

  assign n_hi   = N[2*W-1:W];
  assign n_lo   = N[W-1:0];
  assign accept = in_valid && (state_q == S_IDLE);
  // A high half >= D means the quotient cannot fit; D==0 falls in here too.
  assign n_ovf  = n_hi >= D;

  // Outputs come straight from registers; handshakes decode the state flop.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign Q         = q_q;
  assign Rem       = rem_q;
  assign ovf       = ovf_q;

  // One restoring step: shift in next dividend bit, subtract if it fits.
  always_comb begin
    t       = {r_q[W-1:0], s_q[W-1]};
    diff    = t - {1'b0, dv_q};
    qbit    = (t >= {1'b0, dv_q});
    r_next  = qbit ? diff : t;
    qa_next = {qa_q[W-2:0], qbit};
    last    = (cnt_q == CW'(W - 1));
  end

  // Next-state and datapath register update.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    s_d     = s_q;
    dv_d    = dv_q;
    qa_d    = qa_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (n_ovf) begin
            q_d     = '1;
            rem_d   = '0;
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            r_d     = {1'b0, n_hi};
            s_d     = n_lo;
            dv_d    = D;
            qa_d    = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        r_d   = r_next;
        s_d   = {s_q[W-2:0], 1'b0};
        qa_d  = qa_next;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          q_d     = qa_next;
          rem_d   = r_next[W-1:0];
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath flops with synchronous reset that drops any op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      s_q     <= '0;
      dv_q    <= '0;
      qa_q    <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      s_q     <= s_d;
      dv_q    <= dv_d;
      qa_q    <= qa_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_bdiv56x28.sv
// tb_bdiv56x28: directed and random checks of bdiv56x28
// against an arithmetic reference model.
module tb_bdiv56x28;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [55:0] N = '0;
  logic [27:0] D = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [27:0] Q;
  logic [27:0] Rem;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  bdiv56x28 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .N(N), .D(D),
    .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .Rem(Rem), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: plain integer division on the full-width dividend.
  function automatic logic [56:0] ref_div(input logic [55:0] n,
                                          input logic [27:0] d);
    longint unsigned nn, dd;
    nn = 64'(n);
    dd = 64'(d);
    if ((nn >> 28) >= dd) return {1'b1, 28'hFFFFFFF, 28'd0};
    return {1'b0, 28'(nn / dd), 28'(nn % dd)};
  endfunction

  // Model: 0=idle, 1=busy, 2=result held.
  int          m_mode = 0;
  int          m_left = 0;
  logic        m_live = 1'b0;
  logic [27:0] m_q = '0, m_rem = '0, p_q = '0, p_r = '0;
  logic        m_ovf = 1'b0;
  logic [56:0] m_res;

  assign m_res = ref_div(N, D);

  always @(posedge clk) begin
    if (rst) begin
      m_mode <= 0;
      m_q    <= '0;
      m_rem  <= '0;
      m_ovf  <= 1'b0;
      m_live <= 1'b1;
    end else begin
      case (m_mode)
        0: if (in_valid) begin
          if (m_res[56]) begin
            m_q    <= m_res[55:28];
            m_rem  <= m_res[27:0];
            m_ovf  <= 1'b1;
            m_mode <= 2;
          end else begin
            p_q    <= m_res[55:28];
            p_r    <= m_res[27:0];
            m_ovf  <= 1'b0;
            m_left <= 28;
            m_mode <= 1;
          end
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_q    <= p_q;
            m_rem  <= p_r;
            m_mode <= 2;
          end
        end
        default: if (out_ready) m_mode <= 0;
      endcase
    end
  end

  // Every cycle after the first reset, all outputs must match the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("out_valid", 64'(out_valid), 64'(m_mode == 2));
      chk("in_ready", 64'(in_ready), 64'(m_mode == 0));
      chk("Q", 64'(Q), 64'(m_q));
      chk("Rem", 64'(Rem), 64'(m_rem));
      chk("ovf", 64'(ovf), 64'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_op(input logic [55:0] n, input logic [27:0] d);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    N = n;
    D = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    N = {$urandom, $urandom};
    D = 28'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL out_valid_timeout: got 0 expected 1");
    end
  endtask

  task automatic release_out(input int stall);
    repeat (stall) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [55:0] n, input logic [27:0] d,
                        input int stall, output int lat);
    accept_op(n, d);
    wait_out(lat);
    release_out(stall);
  endtask

  initial begin
    int lat;
    longint unsigned a, b, r;
    logic [55:0] nv;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_Q", 64'(Q), 64'd0);

    run_op(56'd7, 28'd2, 0, lat);
    chk("lat_7_2", 64'(lat), 64'd28);
    chk("Q_7_2", 64'(Q), 64'd3);
    chk("Rem_7_2", 64'(Rem), 64'd1);
    chk("ovf_7_2", 64'(ovf), 64'd0);

    run_op(56'hFFFFFFE0000001, 28'hFFFFFFF, 1, lat);
    chk("Q_max", 64'(Q), 64'hFFFFFFF);
    chk("Rem_max", 64'(Rem), 64'd0);
    chk("ovf_max", 64'(ovf), 64'd0);

    run_op(56'h123, 28'd0, 0, lat);
    chk("lat_d0", 64'(lat), 64'd0);
    chk("ovf_d0", 64'(ovf), 64'd1);
    chk("Q_d0", 64'(Q), 64'hFFFFFFF);
    chk("Rem_d0", 64'(Rem), 64'd0);

    run_op(56'h00000050000000, 28'd5, 2, lat);
    chk("lat_ovf5", 64'(lat), 64'd0);
    chk("ovf_5", 64'(ovf), 64'd1);

    run_op(56'h00000040000000, 28'd5, 0, lat);
    chk("ovf_4", 64'(ovf), 64'd0);
    chk("Q_4", 64'(Q), 64'hCCCCCCC);
    chk("Rem_4", 64'(Rem), 64'd4);

    // Backpressure: result held for 10 cycles.
    accept_op(56'd12345678, 28'd1000);
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_ready", 64'(in_ready), 64'd0);
      chk("bp_Q", 64'(Q), 64'd12345);
      chk("bp_Rem", 64'(Rem), 64'd678);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle", 64'(in_ready), 64'd1);
    run_op(56'd1000, 28'd3, 0, lat);
    chk("bp2_Q", 64'(Q), 64'd333);
    chk("bp2_Rem", 64'(Rem), 64'd1);

    // Reset in the middle of a calculation.
    accept_op(56'hFFFFFFE0000001, 28'hFFFFFFF);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_ready", 64'(in_ready), 64'd1);
    chk("mr_Q", 64'(Q), 64'd0);
    chk("mr_Rem", 64'(Rem), 64'd0);
    chk("mr_ovf", 64'(ovf), 64'd0);
    run_op(56'd100, 28'd7, 0, lat);
    chk("mr2_Q", 64'(Q), 64'd14);
    chk("mr2_Rem", 64'(Rem), 64'd2);

    // Random A*B+R with R<B, with random output stalls.
    for (int i = 0; i < 300; i++) begin
      b = 64'($urandom_range(1, 28'hFFFFFFF));
      if (i % 4 == 0) b = 64'($urandom_range(1, 255));
      a = 64'($urandom_range(0, 28'hFFFFFFF));
      r = 64'($urandom) % b;
      nv = 56'(a * b + r);
      run_op(nv, 28'(b), $urandom_range(0, 3), lat);
      chk("rnd_Q", 64'(Q), a);
      chk("rnd_Rem", 64'(Rem), r);
      chk("rnd_ovf", 64'(ovf), 64'd0);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
